// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative multiply/divide unit for the eight RV32M operations.
// Accepts one operation at a time, iterates BITS_PER_CYCLE bits per clock,
// and holds the result behind a valid/ready handshake until it is taken.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   flush                 abandon any operation in flight; no result is emitted
//   in_valid / in_ready   operation handshake (in_ready only in IDLE without flush)
//   in_op                 funct3: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
//   in_r1, in_r2          source operand values
//   in_rd, in_rd_enable   destination register and write-back request
//   out_valid / out_ready result handshake
//   out_result            result value
//   out_rd, out_rd_enable destination copy; enable is suppressed for x0
//   busy                  an operation is in flight or waiting to be taken
module ex_muldiv #(
   parameter int XLEN           = 32,
   parameter int BITS_PER_CYCLE = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [2:0]      in_op,
   input  logic [XLEN-1:0] in_r1,
   input  logic [XLEN-1:0] in_r2,
   input  logic [4:0]      in_rd,
   input  logic            in_rd_enable,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_result,
   output logic [4:0]      out_rd,
   output logic            out_rd_enable,
   output logic            busy
);

   localparam int B  = BITS_PER_CYCLE;
   localparam int N  = XLEN / BITS_PER_CYCLE;
   localparam int CW = $clog2(N + 1);

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

   state_t            state_reg, state_next;
   logic [CW-1:0]     cnt_reg;
   logic [2:0]        op_reg;
   logic [4:0]        rd_reg;
   logic              rd_en_reg;
   logic              sign1_reg, sign2_reg;
   logic              fast_reg;
   logic [XLEN-1:0]   hi_reg, lo_reg, d_reg;
   logic [XLEN-1:0]   result_reg;

   logic              accept;
   logic              sign1, sign2;
   logic [XLEN-1:0]   mag1, mag2;
   logic              div_zero, div_ovf, fast;
   logic [XLEN-1:0]   fast_val;

   logic [XLEN+B-1:0] mul_acc;
   logic [XLEN-1:0]   div_rem, div_quo;
   logic [XLEN:0]     div_t, div_diff;
   logic              div_ge;
   logic [XLEN-1:0]   hi_next, lo_next;
   logic [2*XLEN-1:0] prod_fix;
   logic [XLEN-1:0]   quo_fix, rem_fix, final_val;

   assign accept = in_valid && in_ready;

   // Operand preparation: iterate on magnitudes, remember which operands were negative.
   always_comb begin
      sign1    = in_r1[XLEN-1] && (in_op == 3'd1 || in_op == 3'd2 || in_op == 3'd4 || in_op == 3'd6);
      sign2    = in_r2[XLEN-1] && (in_op == 3'd1 || in_op == 3'd4 || in_op == 3'd6);
      mag1     = sign1 ? -in_r1 : in_r1;
      mag2     = sign2 ? -in_r2 : in_r2;
      div_zero = (in_r2 == '0);
      div_ovf  = !in_op[0] && (in_r1 == {1'b1, {(XLEN-1){1'b0}}}) && (in_r2 == '1);
      fast     = in_op[2] && (div_zero || div_ovf);
      // in_op[1] separates REM/REMU from DIV/DIVU
      if (div_zero) fast_val = in_op[1] ? in_r1 : '1;
      else          fast_val = in_op[1] ? '0 : in_r1;
   end

   // One iteration step for both datapaths. {hi, lo} is the shared working register:
   // multiply keeps partial product high / remaining multiplier low,
   // divide keeps partial remainder high / dividend-becoming-quotient low.
   always_comb begin
      mul_acc = {{B{1'b0}}, hi_reg};
      for (int i = 0; i < B; i++) begin
         if (lo_reg[i]) mul_acc = mul_acc + ({{B{1'b0}}, d_reg} << i);
      end

      div_rem  = hi_reg;
      div_quo  = lo_reg;
      div_t    = '0;
      div_diff = '0;
      div_ge   = 1'b0;
      for (int i = 0; i < B; i++) begin
         div_t    = {div_rem, div_quo[XLEN-1]};
         div_diff = div_t - {1'b0, d_reg};
         div_ge   = (div_t >= {1'b0, d_reg});
         div_rem  = div_ge ? div_diff[XLEN-1:0] : div_t[XLEN-1:0];
         div_quo  = {div_quo[XLEN-2:0], div_ge};
      end

      if (op_reg[2]) begin
         hi_next = div_rem;
         lo_next = div_quo;
      end else begin
         hi_next = mul_acc[XLEN+B-1:B];
         lo_next = {mul_acc[B-1:0], lo_reg[XLEN-1:B]};
      end
   end

   // Sign correction and result selection from the final iteration's output.
   always_comb begin
      prod_fix = (sign1_reg ^ sign2_reg) ? -{hi_next, lo_next} : {hi_next, lo_next};
      quo_fix  = (sign1_reg ^ sign2_reg) ? -lo_next : lo_next;
      rem_fix  = sign1_reg ? -hi_next : hi_next;
      case (op_reg)
         3'd0:                final_val = prod_fix[XLEN-1:0];
         3'd1, 3'd2, 3'd3:    final_val = prod_fix[2*XLEN-1:XLEN];
         3'd4, 3'd5:          final_val = quo_fix;
         default:             final_val = rem_fix;
      endcase
   end

   // FSM: state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_reg <= S_IDLE;
      else     state_reg <= state_next;
   end

   // FSM: next state
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IDLE:  if (accept) state_next = S_BUSY;
         S_BUSY:  if (flush) state_next = S_IDLE;
                  else if (cnt_reg == CW'(1)) state_next = S_DONE;
         S_DONE:  if (flush || out_ready) state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   // FSM: outputs
   always_comb begin
      in_ready  = (state_reg == S_IDLE) && !flush;
      busy      = (state_reg != S_IDLE);
      out_valid = (state_reg == S_DONE);
   end

   // Datapath. Fast-path results are settled at accept and then pass through a
   // single BUSY cycle, so every op reaches DONE through the same counter exit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_reg    <= '0;
         op_reg     <= '0;
         rd_reg     <= '0;
         rd_en_reg  <= 1'b0;
         sign1_reg  <= 1'b0;
         sign2_reg  <= 1'b0;
         fast_reg   <= 1'b0;
         hi_reg     <= '0;
         lo_reg     <= '0;
         d_reg      <= '0;
         result_reg <= '0;
      end else if (accept) begin
         op_reg    <= in_op;
         rd_reg    <= in_rd;
         rd_en_reg <= in_rd_enable && (in_rd != 5'd0);
         sign1_reg <= sign1;
         sign2_reg <= sign2;
         fast_reg  <= fast;
         hi_reg    <= '0;
         lo_reg    <= mag1;
         d_reg     <= mag2;
         cnt_reg   <= fast ? CW'(1) : CW'(N);
         if (fast) result_reg <= fast_val;
      end else if (state_reg == S_BUSY && !flush) begin
         cnt_reg <= cnt_reg - CW'(1);
         hi_reg  <= hi_next;
         lo_reg  <= lo_next;
         if (cnt_reg == CW'(1) && !fast_reg) result_reg <= final_val;
      end
   end

   assign out_result    = result_reg;
   assign out_rd        = rd_reg;
   assign out_rd_enable = rd_en_reg;

endmodule

// File: tb/tb_ex_muldiv.sv
module tb_ex_muldiv;
   localparam logic [31:0] MINV = 32'h8000_0000;

   typedef struct {
      logic [31:0] result;
      logic [4:0]  rd;
      logic        rde;
   } exp_t;

   logic        clk, rst;
   logic        flush_s        [2];
   logic        in_valid_s     [2];
   logic        in_ready_s     [2];
   logic [2:0]  in_op_s        [2];
   logic [31:0] in_r1_s        [2];
   logic [31:0] in_r2_s        [2];
   logic [4:0]  in_rd_s        [2];
   logic        in_rd_enable_s [2];
   logic        out_valid_s    [2];
   logic        out_ready_s    [2];
   logic [31:0] out_result_s   [2];
   logic [4:0]  out_rd_s       [2];
   logic        out_rd_enable_s[2];
   logic        busy_s         [2];

   exp_t exp_q[$];
   int   checks = 0;
   int   failures = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   ex_muldiv #(.XLEN(32), .BITS_PER_CYCLE(1)) dut (
      .clk(clk), .rst(rst), .flush(flush_s[0]),
      .in_valid(in_valid_s[0]), .in_ready(in_ready_s[0]), .in_op(in_op_s[0]),
      .in_r1(in_r1_s[0]), .in_r2(in_r2_s[0]), .in_rd(in_rd_s[0]), .in_rd_enable(in_rd_enable_s[0]),
      .out_valid(out_valid_s[0]), .out_ready(out_ready_s[0]), .out_result(out_result_s[0]),
      .out_rd(out_rd_s[0]), .out_rd_enable(out_rd_enable_s[0]), .busy(busy_s[0]));

   ex_muldiv #(.XLEN(32), .BITS_PER_CYCLE(4)) dut4 (
      .clk(clk), .rst(rst), .flush(flush_s[1]),
      .in_valid(in_valid_s[1]), .in_ready(in_ready_s[1]), .in_op(in_op_s[1]),
      .in_r1(in_r1_s[1]), .in_r2(in_r2_s[1]), .in_rd(in_rd_s[1]), .in_rd_enable(in_rd_enable_s[1]),
      .out_valid(out_valid_s[1]), .out_ready(out_ready_s[1]), .out_result(out_result_s[1]),
      .out_rd(out_rd_s[1]), .out_rd_enable(out_rd_enable_s[1]), .busy(busy_s[1]));

   // Reference model: plain 64-bit arithmetic following the RV32M rules.
   function automatic logic [31:0] model(logic [2:0] op, logic [31:0] a, logic [31:0] b);
      longint      sa, sb, ua, ub;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = longint'({32'd0, a});
      ub = longint'({32'd0, b});
      p  = '0;
      case (op)
         3'd0: begin p = sa * sb; return p[31:0]; end
         3'd1: begin p = sa * sb; return p[63:32]; end
         3'd2: begin p = sa * ub; return p[63:32]; end
         3'd3: begin p = ua * ub; return p[63:32]; end
         3'd4: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (a == MINV && b == 32'hFFFF_FFFF) return a;
            p = sa / sb; return p[31:0];
         end
         3'd5: begin
            if (b == 0) return 32'hFFFF_FFFF;
            p = ua / ub; return p[31:0];
         end
         3'd6: begin
            if (b == 0) return a;
            if (a == MINV && b == 32'hFFFF_FFFF) return 32'd0;
            p = sa % sb; return p[31:0];
         end
         default: begin
            if (b == 0) return a;
            p = ua % ub; return p[31:0];
         end
      endcase
   endfunction

   function automatic bit is_fast(logic [2:0] op, logic [31:0] a, logic [31:0] b);
      if (op < 3'd4) return 1'b0;
      if (b == 0) return 1'b1;
      return (op == 3'd4 || op == 3'd6) && a == MINV && b == 32'hFFFF_FFFF;
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0:       return 32'd0;
         1:       return 32'hFFFF_FFFF;
         2:       return MINV;
         3:       return 32'd1;
         default: return $urandom;
      endcase
   endfunction

   task automatic check(string name, logic [63:0] act, logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
      end
   endtask

   // Monitor: every result the consumer takes is compared with the oldest expectation.
   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         for (int u = 0; u < 2; u++) begin
            if (!rst && out_valid_s[u] && out_ready_s[u] && !flush_s[u]) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL unexpected_result unit=%0d actual=%h required=none", u, out_result_s[u]);
               end else begin
                  e = exp_q.pop_front();
                  $display("txn unit=%0d result=%h expected=%h rd=%0d rde=%0b",
                           u, out_result_s[u], e.result, out_rd_s[u], out_rd_enable_s[u]);
                  check("result", {32'd0, out_result_s[u]}, {32'd0, e.result});
                  check("rd_copy", {58'd0, out_rd_enable_s[u], out_rd_s[u]}, {58'd0, e.rde, e.rd});
               end
            end
         end
      end
   end

   // Present an op and wait for it to be accepted; the expectation is queued at the accept edge.
   task automatic start_op(int u, logic [2:0] op, logic [31:0] a, logic [31:0] b,
                           logic [4:0] rd, logic rde, output bit ok);
      exp_t e;
      int   w;
      ok = 1'b0;
      in_valid_s[u] = 1'b1;
      in_op_s[u] = op;
      in_r1_s[u] = a;
      in_r2_s[u] = b;
      in_rd_s[u] = rd;
      in_rd_enable_s[u] = rde;
      w = 0;
      @(negedge clk);
      while (!in_ready_s[u] && w < 50) begin
         @(negedge clk);
         w++;
      end
      if (!in_ready_s[u]) begin
         check("accept_timeout", 64'd0, 64'd1);
         in_valid_s[u] = 1'b0;
         return;
      end
      @(posedge clk);
      e.result = model(op, a, b);
      e.rd = rd;
      e.rde = rde && (rd != 5'd0);
      exp_q.push_back(e);
      #1;
      in_valid_s[u] = 1'b0;
      ok = 1'b1;
   endtask

   // Wait for out_valid, check latency, optionally stall the consumer, then release.
   task automatic wait_done(int u, logic [2:0] op, logic [31:0] a, logic [31:0] b, int hold);
      int          e, lat;
      bit          seen;
      logic [31:0] sv_res;
      logic [4:0]  sv_rd;
      lat = is_fast(op, a, b) ? 1 : (u == 0 ? 32 : 8);
      out_ready_s[u] = (hold == 0);
      e = 0;
      seen = 1'b0;
      while (e < 200 && !seen) begin
         @(posedge clk);
         #1;
         e++;
         seen = out_valid_s[u];
      end
      check("latency", seen ? 64'(e) : 64'hDEAD, 64'(lat));
      if (!seen) begin
         out_ready_s[u] = 1'b1;
         return;
      end
      if (hold > 0) begin
         sv_res = out_result_s[u];
         sv_rd  = out_rd_s[u];
         for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            check("hold_stable", {25'd0, out_valid_s[u], in_ready_s[u], out_rd_s[u], out_result_s[u]},
                  {25'd0, 1'b1, 1'b0, sv_rd, sv_res});
         end
         out_ready_s[u] = 1'b1;
      end
      @(posedge clk);
      #1;
      check("release_idle", {61'd0, in_ready_s[u], out_valid_s[u], busy_s[u]}, 64'b100);
   endtask

   task automatic run_op(int u, logic [2:0] op, logic [31:0] a, logic [31:0] b,
                         logic [4:0] rd, logic rde, int hold);
      bit ok;
      start_op(u, op, a, b, rd, rde, ok);
      if (ok) wait_done(u, op, a, b, hold);
   endtask

   logic [2:0]  d_op [12] = '{3'd0, 3'd3, 3'd1, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd7, 3'd4, 3'd6};
   logic [31:0] d_a  [12] = '{32'd7, 32'hFFFF_FFFF, MINV, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                              32'd100, 32'd100, 32'd5, 32'd5, MINV, MINV};
   logic [31:0] d_b  [12] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, MINV, 32'hFFFF_FFFF, 32'd2, 32'd2,
                              32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};

   initial begin : stimulus
      bit ok;
      int cnt, w;
      rst = 1'b1;
      for (int u = 0; u < 2; u++) begin
         flush_s[u] = 1'b0;
         in_valid_s[u] = 1'b0;
         in_op_s[u] = '0;
         in_r1_s[u] = '0;
         in_r2_s[u] = '0;
         in_rd_s[u] = '0;
         in_rd_enable_s[u] = 1'b0;
         out_ready_s[u] = 1'b1;
      end
      repeat (3) @(posedge clk);
      #1;
      for (int u = 0; u < 2; u++)
         check("reset_outputs", {24'd0, out_valid_s[u], busy_s[u], out_rd_enable_s[u], out_rd_s[u], out_result_s[u]}, 64'd0);
      rst = 1'b0;
      #1;
      for (int u = 0; u < 2; u++) check("ready_after_reset", {63'd0, in_ready_s[u]}, 64'd1);

      // Directed vectors, including divide-by-zero and signed overflow.
      for (int i = 0; i < 12; i++) run_op(0, d_op[i], d_a[i], d_b[i], 5'(i + 1), 1'b1, 0);

      // Consumer stall in DONE, and write-back suppressed for x0.
      run_op(0, 3'd5, 32'd1000, 32'd7, 5'd9, 1'b1, 5);
      run_op(0, 3'd0, 32'd3, 32'd4, 5'd0, 1'b1, 0);

      // Flush part-way through a divide.
      start_op(0, 3'd4, $urandom, 32'd7, 5'd3, 1'b1, ok);
      if (ok) begin
         repeat (10) @(posedge clk);
         #1;
         flush_s[0] = 1'b1;
         exp_q.delete();
         @(posedge clk);
         #1;
         flush_s[0] = 1'b0;
         check("flush_busy_idle", {62'd0, busy_s[0], out_valid_s[0]}, 64'd0);
         cnt = 0;
         repeat (40) begin
            @(posedge clk);
            #1;
            if (out_valid_s[0]) cnt++;
         end
         check("flush_no_valid", 64'(cnt), 64'd0);
      end

      // Flush together with in_valid in IDLE: nothing accepted.
      in_valid_s[0] = 1'b1;
      in_op_s[0] = 3'd0;
      flush_s[0] = 1'b1;
      @(negedge clk);
      check("flush_blocks_ready", {63'd0, in_ready_s[0]}, 64'd0);
      @(posedge clk);
      #1;
      in_valid_s[0] = 1'b0;
      flush_s[0] = 1'b0;
      check("flush_no_accept", {63'd0, busy_s[0]}, 64'd0);

      // Flush beats a same-cycle result handshake in DONE.
      out_ready_s[0] = 1'b0;
      start_op(0, 3'd5, 32'd77, 32'd0, 5'd4, 1'b1, ok);
      if (ok) begin
         w = 0;
         while (!out_valid_s[0] && w < 100) begin
            @(posedge clk);
            #1;
            w++;
         end
         check("done_reached", {63'd0, out_valid_s[0]}, 64'd1);
         flush_s[0] = 1'b1;
         out_ready_s[0] = 1'b1;
         exp_q.delete();
         @(posedge clk);
         #1;
         flush_s[0] = 1'b0;
         check("flush_done_drop", {62'd0, busy_s[0], out_valid_s[0]}, 64'd0);
      end
      out_ready_s[0] = 1'b1;

      // Randomized ops against the reference model.
      for (int i = 0; i < 40; i++)
         run_op(0, 3'($urandom_range(0, 7)), pick(), pick(), 5'($urandom), 1'($urandom),
                ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0);

      // Asynchronous reset in the middle of an iteration.
      run_op(0, 3'd0, 32'd3, 32'd5, 5'd4, 1'b1, 0);
      start_op(0, 3'd4, 32'd1000, 32'd3, 5'd6, 1'b1, ok);
      if (ok) begin
         repeat (10) @(posedge clk);
         #3;
         rst = 1'b1;
         #1;
         check("async_reset_outputs", {24'd0, out_valid_s[0], busy_s[0], out_rd_enable_s[0], out_rd_s[0], out_result_s[0]}, 64'd0);
         exp_q.delete();
         #4;
         rst = 1'b0;
         #1;
         check("ready_after_midreset", {62'd0, in_ready_s[0], busy_s[0]}, 64'b10);
         @(posedge clk);
         #1;
      end
      run_op(0, 3'd5, 32'd100, 32'd7, 5'd2, 1'b1, 0);

      // Four bits per cycle.
      run_op(1, 3'd5, 32'd100, 32'd7, 5'd5, 1'b1, 0);
      for (int i = 0; i < 15; i++)
         run_op(1, 3'($urandom_range(0, 7)), pick(), pick(), 5'($urandom), 1'($urandom), 0);

      repeat (3) @(posedge clk);
      check("queue_drained", 64'(exp_q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ex_muldiv.md
# ex_muldiv

Iterative RV32M multiply/divide execution unit, parametrised in datapath width and bits retired per cycle. Sits beside the single-cycle integer EX stage: the decoder steers M-extension ops here, the pipeline stalls on `in_ready` low, and the result is handed to MEM/WB through a valid/ready pair. Implements all eight M ops with RISC-V divide-by-zero and signed-overflow semantics, plus flush on branch mispredict.

## Interface

Parameters:
- `XLEN`, 32, operand/result width.
- `BITS_PER_CYCLE`, 1, quotient/multiplier bits retired per iteration; legal 1, 2, 4; must divide `XLEN`.
- `N` (localparam) = `XLEN / BITS_PER_CYCLE`, iteration count.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `flush` in 1: kill in-flight op (mispredict).
- `in_valid` in 1: op presented.
- `in_ready` out 1: unit can accept (state IDLE and `flush` low).
- `in_op` in 3: funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- `in_r1`, `in_r2` in XLEN: rs1, rs2 values.
- `in_rd` in 5: destination register.
- `in_rd_enable` in 1: write-back requested.
- `out_valid` out 1: result held.
- `out_ready` in 1: consumer takes result.
- `out_result` out XLEN: result.
- `out_rd` out 5, `out_rd_enable` out 1: registered copies; `out_rd_enable` = `in_rd_enable && in_rd != 0`.
- `busy` out 1: state != IDLE.

## Operation

- FSM: IDLE, BUSY, DONE.
- IDLE: accept when `in_valid && in_ready`. At accept edge latch op, rd, rd_enable; latch operand magnitudes and sign flags (signed operands per op: MULH both, MULHSU rs1 only, DIV/REM both); load counter = N.
- Fast path at accept: divisor 0 -> DONE directly (DIV/DIVU: all ones; REM/REMU: rs1). DIV/REM with rs1 = most-negative and rs2 = -1 -> DONE (DIV: rs1; REM: 0). No iteration.
- BUSY: one iteration per edge, counter decrements. Multiply: shift-add of `BITS_PER_CYCLE` multiplier bits into 2·XLEN accumulator. Divide: restoring, `BITS_PER_CYCLE` quotient bits per edge. On the edge where counter goes 1 -> 0, sign-correct and register final value into `out_result`, go DONE.
- Result select: MUL low XLEN of product; MULH/MULHSU/MULHU high XLEN of signed/signed-unsigned/unsigned 2·XLEN product. Quotient sign = sign(r1) XOR sign(r2); remainder sign = sign(r1). All arithmetic modulo 2^XLEN.
- DONE: `out_valid` = 1; `out_result`, `out_rd`, `out_rd_enable` stable while `out_ready` low. `out_valid && out_ready` -> IDLE next edge. No accept in DONE (no overlap).
- `flush` high at an edge: from any state go IDLE, `out_valid` 0 next cycle, no result emitted. Flush beats same-cycle `in_valid` (not accepted) and same-cycle `out_ready` handshake (result dropped).
- Reset (any time, mid-op included): state IDLE, `out_valid` 0, `out_result` 0, `out_rd` 0, `out_rd_enable` 0, `busy` 0, counter 0, internal accumulators 0. `in_ready` 1 once `rst` deasserts.

## Timing

- Normal op: accept at edge k; `out_valid` rises after edge k+N (32 for default). Fast path: `out_valid` after edge k+1.
- Back-to-back: handshake at edge j -> IDLE; next accept earliest edge j+1. Throughput 1 op per N+2 cycles minimum.
- `in_ready` combinational from state and `flush`; all other outputs registered.
- BITS_PER_CYCLE = 4, XLEN = 32: `out_valid` after edge k+8.

## Test plan

- MUL 7 × 0xFFFFFFFD -> 0xFFFFFFEB, `out_valid` exactly 32 edges after accept; MULHU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFE; MULH 0x80000000 × 0x80000000 -> 0x40000000; MULHSU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD, REM -> 0xFFFFFFFF; DIVU 100 / 7 -> 14, REMU -> 2.
- DIV 5 / 0 -> 0xFFFFFFFF, REMU 5 / 0 -> 5, DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, REM -> 0; each valid 1 edge after accept.
- `out_ready` held low 5 cycles in DONE -> `out_valid`, `out_result`, `out_rd` constant; `in_ready` low throughout; handshake -> `in_ready` high next cycle.
- `flush` at iteration 10 of a DIV -> IDLE next edge, no `out_valid` ever; `flush` with `in_valid` in IDLE -> op not accepted.
- `rst` asserted mid-BUSY (asynchronously, between edges) -> all outputs at reset values immediately; rerun with BITS_PER_CYCLE = 4: DIVU 100 / 7 -> 14 after 8 edges.
